bus_src_arbiter: RTL and testbench
==================================

BUS_SRC_ARBITER -- requirements
Module: bus_src_arbiter

Interface
- REQ-001 Parameter NUM_SRC, default 24: number of bus sources (R0-R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C), valid range 2-64.
- REQ-002 Parameter SEL_W, default $clog2(NUM_SRC): width of sel.
- REQ-003 Parameter MAX_HOLD, default 16: maximum grant length in cycles, range 1-255.
- REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
- REQ-005 clock  input  1  sole clock; all state updates on rising edge.
- REQ-006 clear_n  input  1  asynchronous, active-low reset.
- REQ-007 req  input  NUM_SRC  per-source bus request; bit i is source i.
- REQ-008 release  input  1  current owner finished; sampled only in GRANT.
- REQ-009 sel  output  SEL_W  registered encoded index of the bus owner.
- REQ-010 grant_valid  output  1  registered; high while sel drives the bus mux.
- REQ-011 multi_req  output  1  registered; high for one cycle when a grant is issued while more than one unblocked req bit is set.
- REQ-012 timeout  output  1  registered one-cycle pulse on forced release.

Function
- REQ-013 The FSM SHALL have states IDLE, GRANT and TURN.
- REQ-014 IDLE: if any unblocked req bit is set, register the winner into sel, set grant_valid=1 on the next edge, and go to GRANT; otherwise stay, grant_valid=0.
- REQ-015 Fixed priority (default): the lowest set unblocked index wins.
- REQ-016 GRANT: sel SHALL be held constant; hold counter increments each cycle, starting at 1 on grant entry.
- REQ-017 GRANT exit: release=1 or req[sel]=0 -> TURN, grant_valid=0 on the next edge.
- REQ-018 GRANT exit on hold limit: hold counter = MAX_HOLD with no other exit -> TURN, grant_valid=0, timeout=1 for one cycle, and source sel set blocked.
- REQ-019 Release, req drop and hold limit in the same cycle SHALL be treated as a normal release, with no timeout and no block.
- REQ-020 TURN: one bus-turnaround cycle with grant_valid=0, then unconditionally go to IDLE; requests are not arbitrated in TURN.
- REQ-021 A blocked source SHALL be excluded from arbitration until its req bit is observed low, which clears its block bit.
- REQ-022 sel SHALL retain its last value while grant_valid=0.
- REQ-023 req bits with index >= NUM_SRC do not exist; no out-of-range sel SHALL ever be produced.
- REQ-024 Latency SHALL be: req to grant_valid is 1 cycle from IDLE; release to next possible grant_valid is 3 cycles (GRANT->TURN->IDLE->GRANT).

Reset
- REQ-025 On clear_n=0, asynchronously: state=IDLE, sel=0, grant_valid=0, multi_req=0, timeout=0, hold counter=0, all block bits=0, round-robin pointer=0.
- REQ-026 Reset asserted mid-grant SHALL drop grant_valid immediately, without waiting for a clock edge.
- REQ-027 The first arbitration SHALL occur on the first rising edge after clear_n deasserts.

Configuration
- REQ-028 Macro BUS_SRC_ARBITER_RR_EN.
- REQ-029 When BUS_SRC_ARBITER_RR_EN is defined: round-robin arbitration; the winner is the first set unblocked index at or above pointer, wrapping to 0, and on each grant the pointer becomes (sel+1) mod NUM_SRC.
- REQ-030 When BUS_SRC_ARBITER_RR_EN is undefined: fixed priority per REQ-015; no pointer register is instantiated.

Verification (NUM_SRC=24, MAX_HOLD=8)
- REQ-031 Reset: clear_n=0 with req=all-ones -> sel=0, grant_valid=0, timeout=0, held for the whole reset.
- REQ-032 Priority: req bits 3 and 17 set in IDLE -> next cycle sel=3, grant_valid=1, multi_req=1 for one cycle; drop req[3] -> grant_valid=0, TURN; 2 cycles later sel=17, grant_valid=1.
- REQ-033 Timeout: req bit 5 held steadily -> grant_valid high exactly 8 cycles, timeout pulses once, no re-grant to 5 until req[5] goes low then high again.
- REQ-034 Simultaneous events: release=1 in the cycle the hold count reaches 8 -> timeout=0, source not blocked, re-granted after TURN if still requesting.
- REQ-035 Reset mid-operation: clear_n pulsed low during a grant to source 20 -> grant_valid falls asynchronously; after release of clear_n with req[20]=1 -> sel=20 one cycle later.
- REQ-036 Round-robin (RR_EN defined): req bits 3 and 17 held, release pulsed each grant -> grant sequence 3, 17, 3, 17; without the macro -> 3, 3, 3.

Source files
------------

// File: rtl/bus_src_arbiter.sv
// Bus source arbiter: IDLE/GRANT/TURN FSM with hold limit, timeout blocking and a registered sel.
// Optional round-robin arbitration is enabled with the macro BUS_SRC_ARBITER_RR_EN (default: fixed priority).
module bus_src_arbiter #(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int MAX_HOLD = 16
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               release_bus,
  output logic [SEL_W-1:0]   sel,
  output logic               grant_valid,
  output logic               multi_req,
  output logic               timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [HOLD_W-1:0]    hold_r;
  logic [HOLD_W-1:0]    hold_next_s;
  logic [NUM_SRC-1:0]   block_r;
  logic [NUM_SRC-1:0]   block_next_s;
  logic [NUM_SRC-1:0]   eligible_s;
  logic [SEL_W-1:0]     winner_s;
  logic                 any_s;
  logic                 multi_s;
  logic                 owner_req_s;
  logic [SEL_W-1:0]     sel_next_s;
  logic                 gv_next_s;
  logic                 multi_next_s;
  logic                 timeout_next_s;

  assign eligible_s  = req & ~block_r;
  assign any_s       = |eligible_s;
  assign multi_s     = |(eligible_s & (eligible_s - NUM_SRC'(1'b1)));
  assign owner_req_s = req[sel];

`ifdef BUS_SRC_ARBITER_RR_EN
  logic [SEL_W-1:0]     ptr_r;
  logic [SEL_W-1:0]     ptr_next_s;
  logic [NUM_SRC-1:0]   rot_s;
  logic [SEL_W-1:0]     off_s;
  logic [SEL_W:0]       sum_s;

  // Round-robin search: rotate eligible so ptr sits at bit 0, find the lowest offset, then unrotate.
  always_comb begin
    rot_s = NUM_SRC'({eligible_s, eligible_s} >> ptr_r);
    off_s = {SEL_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? SEL_W'(i) : off_s;
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (sum_s >= (SEL_W + 1)'(NUM_SRC)) begin
      winner_s = SEL_W'(sum_s - (SEL_W + 1)'(NUM_SRC));
    end else begin
      winner_s = sum_s[SEL_W-1:0];
    end
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    winner_s = {SEL_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      winner_s = eligible_s[i] ? SEL_W'(i) : winner_s;
    end
  end
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_next_s   = state_r;
    sel_next_s     = sel;
    gv_next_s      = grant_valid;
    multi_next_s   = 1'b0;
    timeout_next_s = 1'b0;
    hold_next_s    = hold_r;
    block_next_s   = block_r & req;
`ifdef BUS_SRC_ARBITER_RR_EN
    ptr_next_s     = ptr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_next_s = ST_GRANT;
          sel_next_s   = winner_s;
          gv_next_s    = 1'b1;
          multi_next_s = multi_s;
          hold_next_s  = HOLD_W'(1'b1);
`ifdef BUS_SRC_ARBITER_RR_EN
          ptr_next_s   = (winner_s == SEL_W'(NUM_SRC - 1)) ? {SEL_W{1'b0}} : winner_s + SEL_W'(1'b1);
`endif
        end else begin
          gv_next_s = 1'b0;
        end
      end
      ST_GRANT: begin
        // A voluntary exit takes precedence over the hold limit: no timeout, no block.
        if (release_bus || !owner_req_s) begin
          state_next_s = ST_TURN;
          gv_next_s    = 1'b0;
          hold_next_s  = {HOLD_W{1'b0}};
        end else if (hold_r == HOLD_W'(MAX_HOLD)) begin
          state_next_s      = ST_TURN;
          gv_next_s         = 1'b0;
          timeout_next_s    = 1'b1;
          hold_next_s       = {HOLD_W{1'b0}};
          block_next_s[sel] = 1'b1;
        end else begin
          hold_next_s = hold_r + HOLD_W'(1'b1);
        end
      end
      ST_TURN: begin
        state_next_s = ST_IDLE;
        gv_next_s    = 1'b0;
      end
      default: begin
        state_next_s = ST_IDLE;
        gv_next_s    = 1'b0;
        hold_next_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Registered outputs, hold counter and block bits.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sel         <= {SEL_W{1'b0}};
      grant_valid <= 1'b0;
      multi_req   <= 1'b0;
      timeout     <= 1'b0;
      hold_r      <= {HOLD_W{1'b0}};
      block_r     <= {NUM_SRC{1'b0}};
    end else begin
      sel         <= sel_next_s;
      grant_valid <= gv_next_s;
      multi_req   <= multi_next_s;
      timeout     <= timeout_next_s;
      hold_r      <= hold_next_s;
      block_r     <= block_next_s;
    end
  end

`ifdef BUS_SRC_ARBITER_RR_EN
  // Round-robin pointer register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      ptr_r <= {SEL_W{1'b0}};
    end else begin
      ptr_r <= ptr_next_s;
    end
  end
`endif

endmodule

// File: tb/tb_bus_src_arbiter.sv
// Self-checking bench for bus_src_arbiter (NUM_SRC=24, MAX_HOLD=8): vector table plus
// directed sequences for reset, timeout, simultaneous exit, async reset and arbitration order.
module tb_bus_src_arbiter;

  localparam int NS = 24;
  localparam int SW = 5;
  localparam int MH = 8;

  logic          clock = 1'b0;
  logic          clear_n = 1'b0;
  logic [NS-1:0] req = '0;
  logic          release_bus = 1'b0;
  logic [SW-1:0] sel;
  logic          grant_valid;
  logic          multi_req;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NS-1:0] req;
    logic          rel;
    logic [SW-1:0] sel;
    logic          gv;
    logic          mr;
    logic          to;
  } vec_t;

  vec_t vecs[14];

  bus_src_arbiter #(.NUM_SRC(NS), .SEL_W(SW), .MAX_HOLD(MH)) dut (
    .clock(clock),
    .clear_n(clear_n),
    .req(req),
    .release_bus(release_bus),
    .sel(sel),
    .grant_valid(grant_valid),
    .multi_req(multi_req),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [NS-1:0] r, input logic rl, input logic [SW-1:0] s,
                              input logic g, input logic m, input logic t);
    vec_t v;
    v.req = r; v.rel = rl; v.sel = s; v.gv = g; v.mr = m; v.to = t;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    int gv_cnt;
    int to_cnt;
    int to_edge;
    int regrant;
    int waited;
    logic [SW-1:0] got_sel[3];
    logic [SW-1:0] exp_sel[3];

    // Outputs after each vector: {sel, grant_valid, multi_req, timeout}
    vecs[0]  = mk(24'h020008, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0);
    vecs[1]  = mk(24'h020008, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(24'h020000, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(24'h020000, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(24'h020000, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(24'h020000, 1'b1, 5'd17, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(24'h000000, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(24'h000000, 1'b0, 5'd17, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(24'h800001, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0);
    vecs[9]  = mk(24'h800000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    vecs[10] = mk(24'h800000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    vecs[11] = mk(24'h800000, 1'b0, 5'd23, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(24'h000000, 1'b0, 5'd23, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(24'h000000, 1'b0, 5'd23, 1'b0, 1'b0, 1'b0);

    // Reset held with every source requesting
    clear_n = 1'b0;
    req = {NS{1'b1}};
    release_bus = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", {sel, grant_valid, multi_req, timeout}, 8'h00);
    end
    @(negedge clock);
    clear_n = 1'b1;
    step();
    chk("first_arb", {sel, grant_valid, multi_req, timeout}, {5'd0, 1'b1, 1'b1, 1'b0});
    req = '0;
    step();
    step();

    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req;
      release_bus = vecs[i].rel;
      step();
      chk($sformatf("vec%0d", i), {sel, grant_valid, multi_req, timeout},
          {vecs[i].sel, vecs[i].gv, vecs[i].mr, vecs[i].to});
    end
    req = '0;
    release_bus = 1'b0;

    // Hold limit with source 5 requesting steadily
    gv_cnt = 0; to_cnt = 0; to_edge = 0; regrant = 0;
    req = 24'h000020;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (grant_valid) gv_cnt++;
      if (timeout) begin
        to_cnt++;
        to_edge = e;
      end
      if (e > 9 && grant_valid) regrant++;
    end
    chk("to_gv_cycles", gv_cnt, MH);
    chk("to_pulses", to_cnt, 1);
    chk("to_edge", to_edge, 9);
    chk("to_blocked", regrant, 0);
    req = '0;
    step();
    req = 24'h000020;
    step();
    chk("to_unblocked", {sel, grant_valid}, {5'd5, 1'b1});
    req = '0;
    step();
    step();

    // Release in the same cycle the hold count reaches the limit
    req = 24'h000020;
    step();
    for (int i = 0; i < MH - 1; i++) step();
    chk("sim_pre", {sel, grant_valid}, {5'd5, 1'b1});
    release_bus = 1'b1;
    step();
    chk("sim_event", {grant_valid, timeout}, 2'b00);
    release_bus = 1'b0;
    step();
    step();
    chk("sim_regrant", {sel, grant_valid, timeout}, {5'd5, 1'b1, 1'b0});
    req = '0;
    step();
    step();

    // Asynchronous reset during a grant to source 20
    req = 24'h100000;
    step();
    chk("pre_reset_grant", {sel, grant_valid}, {5'd20, 1'b1});
    #2;
    clear_n = 1'b0;
    #1;
    chk("async_drop", {sel, grant_valid, multi_req, timeout}, 8'h00);
    @(negedge clock);
    clear_n = 1'b1;
    step();
    chk("post_reset_grant", {sel, grant_valid}, {5'd20, 1'b1});
    req = '0;
    step();
    step();

    // Arbitration order with sources 3 and 17 held and release pulsed each grant
`ifdef BUS_SRC_ARBITER_RR_EN
    exp_sel[0] = 5'd3; exp_sel[1] = 5'd17; exp_sel[2] = 5'd3;
`else
    exp_sel[0] = 5'd3; exp_sel[1] = 5'd3;  exp_sel[2] = 5'd3;
`endif
    req = 24'h020008;
    for (int g = 0; g < 3; g++) begin
      waited = 0;
      while (!grant_valid && waited < 6) begin
        step();
        waited++;
      end
      chk($sformatf("order_wait%0d", g), grant_valid, 1);
      got_sel[g] = sel;
      chk($sformatf("order_sel%0d", g), got_sel[g], exp_sel[g]);
      release_bus = 1'b1;
      step();
      release_bus = 1'b0;
    end
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
